// File: rtl/tot_fine_code_gen.sv
// tot_fine_code_gen: converts a 5-bit fine phase value into a 21-bit
// delay-line code holding a run of level+1 adjacent ones (mod 21). Values
// come from bin_in (direct mode) or from an internal dwell-paced sweep, and
// pass through a two-stage pipeline: stage 1 holds value/level, stage 2 the code.
module tot_fine_code_gen #(
  parameter int DWELL = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  mode,
  input  logic [4:0]  bin_in,
  input  logic        bin_valid,
  output logic        bin_ready,
  input  logic [1:0]  level,
  output logic [20:0] code_out,
  output logic        code_valid,
  output logic [4:0]  code_bin,
  output logic        range_err,
  output logic        sweep_wrap
);

  typedef enum logic [1:0] {
    IDLE,
    DIRECT,
    SWEEP,
    HOLD
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);
  localparam logic [4:0] BIN_MAX    = 5'd20;

  state_t      state;
  state_t      mode_state;
  logic [4:0]  sweep_bin;
  logic [7:0]  dwell_cnt;

  logic        s1_valid;
  logic        s1_sweep;
  logic [4:0]  s1_bin;
  logic [1:0]  s1_level;

  logic        direct_load;
  logic        sweep_load;
  logic [20:0] next_code;
  logic        next_err;

  // Decode the requested mode; the reserved encoding behaves like hold-last.
  always_comb begin
    mode_state = HOLD;
    case (mode)
      2'b00:   mode_state = DIRECT;
      2'b01:   mode_state = SWEEP;
      default: mode_state = HOLD;
    endcase
  end

  // Loads into stage 1 stop as soon as mode moves away so the pipeline can drain.
  always_comb begin
    bin_ready   = !reset && (state == DIRECT) && (mode == 2'b00);
    direct_load = bin_ready && bin_valid;
    sweep_load  = (state == SWEEP) && (mode == 2'b01);
  end

  // FSM plus sweep position; state only follows mode once stage 1 is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sweep_bin <= '0;
      dwell_cnt <= '0;
    end else begin
      if (!s1_valid) begin
        state <= mode_state;
        if (mode_state == SWEEP && state != SWEEP) begin
          sweep_bin <= '0;
          dwell_cnt <= '0;
        end
      end
      if (sweep_load) begin
        if (dwell_cnt == DWELL_LAST) begin
          dwell_cnt <= '0;
          sweep_bin <= (sweep_bin == BIN_MAX) ? 5'd0 : sweep_bin + 5'd1;
        end else begin
          dwell_cnt <= dwell_cnt + 8'd1;
        end
      end
    end
  end

  // Stage 1 captures the value together with the level it must be encoded with.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_sweep <= 1'b0;
      s1_bin   <= '0;
      s1_level <= '0;
    end else begin
      s1_valid <= direct_load || sweep_load;
      if (direct_load) begin
        s1_bin   <= bin_in;
        s1_level <= level;
        s1_sweep <= 1'b0;
      end else if (sweep_load) begin
        s1_bin   <= sweep_bin;
        s1_level <= level;
        s1_sweep <= 1'b1;
      end
    end
  end

  // Build the contiguous run of ones starting at s1_bin, wrapping past bit 20.
  always_comb begin
    logic [4:0] idx;
    idx       = '0;
    next_code = '0;
    next_err  = 1'b0;
    if (s1_bin > BIN_MAX) begin
      next_err = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (2'(i) <= s1_level) begin
          idx = s1_bin + 5'(i);
          if (idx > BIN_MAX) idx = idx - 5'd21;
          next_code[idx] = 1'b1;
        end
      end
    end
  end

  // Stage 2 presents the code; outputs hold their last value when nothing arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_out   <= '0;
      code_bin   <= '0;
      range_err  <= 1'b0;
      code_valid <= 1'b0;
      sweep_wrap <= 1'b0;
    end else begin
      code_valid <= s1_valid;
      sweep_wrap <= s1_valid && s1_sweep && (s1_bin == 5'd0) &&
                    code_valid && (code_bin == BIN_MAX);
      if (s1_valid) begin
        code_out  <= next_code;
        code_bin  <= s1_bin;
        range_err <= next_err;
      end
    end
  end

endmodule

// File: tb/tb_tot_fine_code_gen.sv
// Directed bench for tot_fine_code_gen: reset state, direct conversions,
// level sampling, full value/level table, hold, sweep with wrap, reset flush.
module tb_tot_fine_code_gen;

  logic        clk;
  logic        reset;
  logic [1:0]  mode;
  logic [4:0]  bin_in;
  logic        bin_valid;
  logic        bin_ready;
  logic [1:0]  level;
  logic [20:0] code_out;
  logic        code_valid;
  logic [4:0]  code_bin;
  logic        range_err;
  logic        sweep_wrap;

  int errors = 0;
  int checks = 0;

  tot_fine_code_gen #(.DWELL(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .mode       (mode),
    .bin_in     (bin_in),
    .bin_valid  (bin_valid),
    .bin_ready  (bin_ready),
    .level      (level),
    .code_out   (code_out),
    .code_valid (code_valid),
    .code_bin   (code_bin),
    .range_err  (range_err),
    .sweep_wrap (sweep_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference code: a run of level+1 ones rotated left by b within 21 bits.
  function automatic logic [20:0] modelCode(input int b, input int lvl);
    logic [20:0] run;
    logic [41:0] wide;
    run  = 21'((1 << (lvl + 1)) - 1);
    wide = {21'b0, run} << b;
    return wide[20:0] | wide[41:21];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [20:0] exp_code,
                             input logic [4:0] exp_bin, input logic exp_valid,
                             input logic exp_err);
    checkVal({tag, "_code"},  32'(code_out),   32'(exp_code));
    checkVal({tag, "_bin"},   32'(code_bin),   32'(exp_bin));
    checkVal({tag, "_valid"}, 32'(code_valid), 32'(exp_valid));
    checkVal({tag, "_err"},   32'(range_err),  32'(exp_err));
  endtask

  task automatic applyStimulus(input logic [4:0] b, input logic [1:0] lvl, input logic v);
    bin_in    = b;
    level     = lvl;
    bin_valid = v;
  endtask

  initial begin
    int n;
    logic [20:0] exp_tab [0:83];
    logic [4:0]  bin_tab [0:83];

    reset = 1'b1;
    mode  = 2'b00;
    applyStimulus(5'd0, 2'd0, 1'b0);
    repeat (3) tick();

    checkOutput("reset", 21'h0, 5'd0, 1'b0, 1'b0);
    checkVal("reset_wrap",  32'(sweep_wrap), 32'd0);
    checkVal("reset_ready", 32'(bin_ready),  32'd0);

    reset = 1'b0;
    #1;
    checkVal("ready_early", 32'(bin_ready), 32'd0);
    tick();
    checkVal("ready_direct", 32'(bin_ready), 32'd1);

    // Direct value 5, level 0
    applyStimulus(5'd5, 2'd0, 1'b1);
    tick();
    applyStimulus(5'd0, 2'd0, 1'b0);
    checkVal("latency1_valid", 32'(code_valid), 32'd0);
    tick();
    checkOutput("dir5", 21'h000020, 5'd5, 1'b1, 1'b0);
    tick();
    checkVal("dir5_drop_valid", 32'(code_valid), 32'd0);
    checkVal("dir5_held_code",  32'(code_out),   32'h000020);

    // Direct value 19, level 3: run wraps into bits 0 and 1
    applyStimulus(5'd19, 2'd3, 1'b1);
    tick();
    applyStimulus(5'd0, 2'd0, 1'b0);
    tick();
    checkOutput("dir19", 21'h180003, 5'd19, 1'b1, 1'b0);

    // Out-of-range value
    applyStimulus(5'd25, 2'd1, 1'b1);
    tick();
    applyStimulus(5'd0, 2'd0, 1'b0);
    tick();
    checkOutput("dir25", 21'h0, 5'd25, 1'b1, 1'b1);

    // Level changing after acceptance must not affect the value in flight
    applyStimulus(5'd10, 2'd0, 1'b1);
    tick();
    applyStimulus(5'd0, 2'd3, 1'b0);
    tick();
    checkOutput("lvl_sample", 21'h000400, 5'd10, 1'b1, 1'b0);

    // Every in-range value at every level, one per cycle
    for (int k = 0; k < 84; k++) begin
      bin_tab[k] = 5'(k % 21);
      exp_tab[k] = modelCode(k % 21, k / 21);
    end
    for (int k = 0; k < 86; k++) begin
      if (k >= 2) begin
        checkVal("table_code",  32'(code_out),   32'(exp_tab[k-2]));
        checkVal("table_bin",   32'(code_bin),   32'(bin_tab[k-2]));
        checkVal("table_valid", 32'(code_valid), 32'd1);
      end
      if (k < 84) applyStimulus(5'(k % 21), 2'(k / 21), 1'b1);
      else        applyStimulus(5'd0, 2'd0, 1'b0);
      tick();
    end

    // Hold-last: outputs freeze, bin_valid is ignored
    applyStimulus(5'd0, 2'd0, 1'b0);
    mode = 2'b10;
    repeat (3) tick();
    checkOutput("hold", 21'h100007, 5'd20, 1'b0, 1'b0);
    checkVal("hold_ready", 32'(bin_ready), 32'd0);
    applyStimulus(5'd7, 2'd0, 1'b1);
    repeat (2) tick();
    checkVal("hold_ignore_valid", 32'(code_valid), 32'd0);
    mode = 2'b11;
    tick();
    checkVal("reserved_ready", 32'(bin_ready), 32'd0);
    checkVal("reserved_code",  32'(code_out),  32'h100007);
    applyStimulus(5'd0, 2'd0, 1'b0);
    mode = 2'b00;
    repeat (4) tick();
    checkVal("noqueue_valid", 32'(code_valid), 32'd0);
    checkVal("noqueue_ready", 32'(bin_ready),  32'd1);

    // Sweep with DWELL=4 and level 0
    mode = 2'b01;
    n = 0;
    while (code_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkVal("sweep_start", 32'(code_valid), 32'd1);
    for (int i = 0; i < 84; i++) begin
      checkVal("sweep_bin",   32'(code_bin),   32'(i / 4));
      checkVal("sweep_code",  32'(code_out),   32'(21'd1 << (i / 4)));
      checkVal("sweep_valid", 32'(code_valid), 32'd1);
      checkVal("sweep_nowrap", 32'(sweep_wrap), 32'd0);
      checkVal("sweep_ready", 32'(bin_ready),  32'd0);
      tick();
    end
    checkVal("wrap_bin",   32'(code_bin),   32'd0);
    checkVal("wrap_pulse", 32'(sweep_wrap), 32'd1);
    tick();
    checkVal("wrap_end",   32'(sweep_wrap), 32'd0);
    checkVal("wrap_hold0", 32'(code_bin),   32'd0);

    // Back to direct, then reset with values in flight
    mode = 2'b00;
    n = 0;
    while (bin_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checkVal("back_direct_ready", 32'(bin_ready), 32'd1);
    applyStimulus(5'd4, 2'd0, 1'b1);
    tick();
    applyStimulus(5'd6, 2'd0, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("flush", 21'h0, 5'd0, 1'b0, 1'b0);
    checkVal("flush_wrap",  32'(sweep_wrap), 32'd0);
    checkVal("flush_ready", 32'(bin_ready),  32'd0);
    applyStimulus(5'd0, 2'd0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checkVal("flush_novalid", 32'(code_valid), 32'd0);
      checkVal("flush_code",    32'(code_out),   32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
